mmio_data_mem: RTL and testbench
================================

Name: mmio_data_mem

Overview:
Data-side memory subsystem sitting directly downstream of minicpu's ram_* port. It consumes the CPU's ram_addr, ram_d_in, ram_rd_ and ram_wr_ and returns ram_d_out. It decodes the 8-bit address space into data RAM plus a memory-mapped I/O page: GPIO, an 8-bit timer and a UART transmitter. Reads are combinational, because the single-cycle CPU consumes ram_d_out in the same cycle (LD/POP/RET). Writes commit on the rising clock edge.

Parameters:
DATA_W, 8, data bus width (matches `DataBus).
ADDR_W, 8, address bus width (matches `AddrBus).
IO_BASE, 8'hF0, first I/O address; RAM occupies 0..IO_BASE-1.
BAUD_DIV, 16, clock cycles per UART bit; must be >= 2.

Ports:
clk  input  1  system clock, rising edge.
rst_  input  1  synchronous reset, active-low.
ram_addr  input  ADDR_W  access address from CPU.
ram_d_in  input  DATA_W  write data from CPU.
ram_d_out  output  DATA_W  read data to CPU.
ram_rd_  input  1  read enable, active-low (`ENABLE_ = 0).
ram_wr_  input  1  write enable, active-low.
gpio_in  input  8  asynchronous external inputs.
gpio_out  output  8  GPIO output register.
uart_tx  output  1  serial transmit line, idle high.
timer_irq  output  1  timer overflow flag (level).

Behaviour:
- Reset:
  - Synchronous, active-low, sampled on the clk rising edge.
  - All registers reset: gpio_out=0, timer count=0, ctrl=0, reload=0, UART FSM=IDLE, uart_tx=1, timer_irq=0, GPIO sync flops=0.
  - RAM contents are not reset.
  - Reset asserted mid-frame aborts the frame; uart_tx=1 after that edge.
- Address map (I/O offsets from IO_BASE):
  - +0 GPIO_OUT (R/W).
  - +1 GPIO_IN (RO): 2-flop synchronised gpio_in.
  - +2 TMR_CNT (R/W).
  - +3 TMR_CTRL: bit0 EN, bit1 AUTO, bit2 FLAG (read; write 1 to clear); other bits read 0.
  - +4 TMR_RELOAD (R/W).
  - +5 UART_DATA (WO; reads 0).
  - +6 UART_STAT: bit0 BUSY.
  - +7..+15 reserved: reads 0, writes ignored.
- Reads:
  - ram_d_out is combinational from ram_addr when ram_rd_=0; ram_d_out=0 when ram_rd_=1.
  - If rd and wr are both active, the read returns the pre-write value.
- Writes:
  - Take effect at the rising edge where ram_wr_=0, and are suppressed while rst_=0.
  - RAM write to an address >= IO_BASE never touches RAM.
- GPIO_IN: a change on gpio_in is visible on reads after 2 clk edges.
- Timer:
  - When EN=1, count increments by 1 per cycle.
  - On the edge where count==8'hFF and EN=1:
    - FLAG is set.
    - If AUTO=1, count<=reload; otherwise count<=8'hFF is held and EN<=0.
  - A CPU write to TMR_CNT in the same cycle as an overflow wins: count<=written value and FLAG is not set that cycle.
  - If a FLAG set and a W1C clear occur in the same cycle, the set wins.
  - timer_irq = FLAG.
- UART TX:
  - FSM states IDLE -> START -> DATA -> STOP -> IDLE.
  - A write to UART_DATA in IDLE latches the byte; BUSY=1 from the next cycle.
  - START drives 0 for BAUD_DIV cycles.
  - DATA drives 8 bits, LSB first, each for BAUD_DIV cycles; a 3-bit bit counter wraps 7->0 and then exits to STOP.
  - STOP drives 1 for BAUD_DIV cycles.
  - Frame length is exactly 10*BAUD_DIV cycles from the capture edge to the return to IDLE; BUSY=0 in IDLE.
  - A write to UART_DATA while BUSY=1 is ignored and the byte is dropped.
  - The baud counter restarts at 0 on each state/bit transition.
- Widths:
  - Counters are unsigned and wrap modulo 2^8.
  - The baud counter width is sized to hold BAUD_DIV-1.

Test Plan:
- Reset then RAM: write 0x5A to 0x10, write 0xA5 to 0xEF; read 0x10 -> 0x5A, read 0xEF -> 0xA5; with ram_rd_=1, ram_d_out=0.
- I/O decode: write 0x3C to 0xF0 -> gpio_out=0x3C next edge; write to 0xF8, then read 0xF8 -> 0; drive gpio_in=0x81 -> read of 0xF1 returns 0x81 after 2 edges and 0x00 before.
- Timer auto-reload: RELOAD=0xFD, CNT=0xFD, CTRL=0x03 -> count 0xFE, 0xFF, 0xFD; timer_irq=1 from the wrap edge; write 0x04 to CTRL -> timer_irq=0.
- Timer one-shot and conflict: CNT=0xFE, CTRL=0x01 -> holds at 0xFF, EN reads 0, FLAG=1. Separately, a CNT write of 0x10 on the overflow cycle -> count=0x10 and FLAG stays 0.
- UART frame (BAUD_DIV=4): write 0xA5 to 0xF5 -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; BUSY=1 for 40 cycles; a second write at cycle 5 is ignored.
- Reset mid-frame: assert rst_=0 at cycle 12 of a frame -> uart_tx=1 and BUSY=0 at the next edge; gpio_out=0; a subsequent write of 0x01 transmits a clean frame.

Source files
------------

// File: rtl/mmio_data_mem_if.sv
// rtl/mmio_data_mem_if.sv - CPU data-port bus bundle for mmio_data_mem
// The CPU drives the master side; the memory subsystem is the slave.
interface mmio_data_mem_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_d_in;
   logic [DATA_W-1:0] ram_d_out;
   logic              ram_rd_;
   logic              ram_wr_;

   modport master (
      output ram_addr, ram_d_in, ram_rd_, ram_wr_,
      input  ram_d_out
   );

   modport slave (
      input  ram_addr, ram_d_in, ram_rd_, ram_wr_,
      output ram_d_out
   );
endinterface

// File: rtl/mmio_data_mem.sv
// rtl/mmio_data_mem.sv - data RAM plus GPIO/timer/UART-TX I/O page for minicpu
// Reads are combinational for the single-cycle CPU; writes commit on the rising edge.
module mmio_data_mem #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned IO_BASE  = 'hF0,
   parameter int unsigned BAUD_DIV = 16
) (
   input  logic            clk,
   input  logic            rst_,
   mmio_data_mem_if.slave  bus,
   input  logic [7:0]      gpio_in,
   output logic [7:0]      gpio_out,
   output logic            uart_tx,
   output logic            timer_irq
);
   localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
   localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(BAUD_DIV - 1);

   localparam logic [ADDR_W-1:0] IO_BASE_A      = ADDR_W'(IO_BASE);
   localparam logic [ADDR_W-1:0] OFF_GPIO_OUT   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] OFF_GPIO_IN    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] OFF_TMR_CNT    = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] OFF_TMR_CTRL   = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] OFF_TMR_RELOAD = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] OFF_UART_DATA  = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] OFF_UART_STAT  = ADDR_W'(6);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_e;

   // ---------------- address decode ----------------
   logic              is_io;
   logic              wr_en;
   logic [ADDR_W-1:0] io_off;
   logic [7:0]        wdata;
   logic              wr_ram, wr_gpio, wr_cnt, wr_ctrl, wr_reload, wr_uart;

   assign is_io     = bus.ram_addr >= IO_BASE_A;
   assign io_off    = bus.ram_addr - IO_BASE_A;
   assign wr_en     = ~bus.ram_wr_;
   assign wdata     = bus.ram_d_in[7:0];
   assign wr_ram    = wr_en & ~is_io;
   assign wr_gpio   = wr_en & is_io & (io_off == OFF_GPIO_OUT);
   assign wr_cnt    = wr_en & is_io & (io_off == OFF_TMR_CNT);
   assign wr_ctrl   = wr_en & is_io & (io_off == OFF_TMR_CTRL);
   assign wr_reload = wr_en & is_io & (io_off == OFF_TMR_RELOAD);
   assign wr_uart   = wr_en & is_io & (io_off == OFF_UART_DATA);

   // ---------------- state ----------------
   logic [DATA_W-1:0] mem_q [IO_BASE];
   logic [7:0]        gpio_q, gpio_d;
   logic [7:0]        sync1_q, sync2_q;
   logic [7:0]        cnt_q, cnt_d;
   logic [7:0]        reload_q, reload_d;
   logic              en_q, en_d;
   logic              auto_q, auto_d;
   logic              flag_q, flag_d;
   logic              tmr_ovf;
   uart_state_e       state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        data_q, data_d;
   logic              tx_q, tx_d;
   logic              baud_done;
   logic [DATA_W-1:0] rd_data;

   // RAM is deliberately left out of reset; only writes below IO_BASE reach it.
   always_ff @(posedge clk) begin
      if (rst_ && wr_ram) begin
         mem_q[bus.ram_addr] <= bus.ram_d_in;
      end
   end

   // ---------------- read mux ----------------
   always_comb begin
      rd_data = '0;
      if (!is_io) begin
         rd_data = mem_q[bus.ram_addr];
      end else begin
         case (io_off)
            OFF_GPIO_OUT:   rd_data = DATA_W'(gpio_q);
            OFF_GPIO_IN:    rd_data = DATA_W'(sync2_q);
            OFF_TMR_CNT:    rd_data = DATA_W'(cnt_q);
            OFF_TMR_CTRL:   rd_data = DATA_W'({5'b0, flag_q, auto_q, en_q});
            OFF_TMR_RELOAD: rd_data = DATA_W'(reload_q);
            OFF_UART_STAT:  rd_data = DATA_W'(state_q != ST_IDLE);
            default:        rd_data = '0;
         endcase
      end
   end

   assign bus.ram_d_out = bus.ram_rd_ ? '0 : rd_data;

   // ---------------- GPIO and timer next state ----------------
   always_comb begin
      gpio_d   = wr_gpio ? wdata : gpio_q;
      reload_d = wr_reload ? wdata : reload_q;
      cnt_d    = cnt_q;
      en_d     = en_q;
      auto_d   = auto_q;
      flag_d   = flag_q;
      // A CPU write to the count cancels an overflow in the same cycle.
      tmr_ovf  = en_q && (cnt_q == 8'hFF) && !wr_cnt;

      if (wr_cnt) begin
         cnt_d = wdata;
      end else if (tmr_ovf) begin
         cnt_d = auto_q ? reload_q : 8'hFF;
      end else if (en_q) begin
         cnt_d = cnt_q + 8'd1;
      end

      if (wr_ctrl) begin
         en_d   = wdata[0];
         auto_d = wdata[1];
      end else if (tmr_ovf && !auto_q) begin
         en_d = 1'b0;
      end

      if (tmr_ovf) begin
         flag_d = 1'b1;
      end else if (wr_ctrl && wdata[2]) begin
         flag_d = 1'b0;
      end
   end

   // ---------------- UART TX next state ----------------
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      data_d    = data_q;
      tx_d      = 1'b1;
      baud_done = (baud_q == BAUD_MAX);

      case (state_q)
         ST_IDLE: begin
            if (wr_uart) begin
               state_d = ST_START;
               data_d  = wdata;
               baud_d  = '0;
               bit_d   = '0;
            end
         end
         ST_START: begin
            if (baud_done) begin
               state_d = ST_DATA;
               baud_d  = '0;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            if (baud_done) begin
               baud_d = '0;
               bit_d  = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_STOP: begin
            if (baud_done) begin
               state_d = ST_IDLE;
               baud_d  = '0;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The line is registered from the next state so it switches on the same edge.
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = data_d[bit_d];
         default:  tx_d = 1'b1;
      endcase
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_) begin
         gpio_q   <= '0;
         sync1_q  <= '0;
         sync2_q  <= '0;
         cnt_q    <= '0;
         reload_q <= '0;
         en_q     <= 1'b0;
         auto_q   <= 1'b0;
         flag_q   <= 1'b0;
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         tx_q     <= 1'b1;
      end else begin
         gpio_q   <= gpio_d;
         sync1_q  <= gpio_in;
         sync2_q  <= sync1_q;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         en_q     <= en_d;
         auto_q   <= auto_d;
         flag_q   <= flag_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         data_q   <= data_d;
         tx_q     <= tx_d;
      end
   end

   assign gpio_out  = gpio_q;
   assign uart_tx   = tx_q;
   assign timer_irq = flag_q;
endmodule

// File: tb/tb_mmio_data_mem.sv
// tb/tb_mmio_data_mem.sv - directed scoreboard bench for mmio_data_mem
// Runs with BAUD_DIV=4 so a UART frame is 40 cycles.
module tb_mmio_data_mem;
   localparam int unsigned BAUD = 4;

   logic       clk = 1'b0;
   logic       rst_;
   logic [7:0] gpio_in;
   logic [7:0] gpio_out;
   logic       uart_tx;
   logic       timer_irq;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   mmio_data_mem_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   mmio_data_mem #(
      .DATA_W(8), .ADDR_W(8), .IO_BASE('hF0), .BAUD_DIV(BAUD)
   ) dut (
      .clk(clk), .rst_(rst_), .bus(bus), .gpio_in(gpio_in),
      .gpio_out(gpio_out), .uart_tx(uart_tx), .timer_irq(timer_irq)
   );

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag, input logic [7:0] obs);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty, observed %02h", tag, obs);
      end else begin
         e = exp_q.pop_front();
         chk(tag, obs, e);
      end
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      bus.ram_addr = addr;
      bus.ram_d_in = data;
      bus.ram_wr_  = 1'b0;
      cyc(1);
      bus.ram_wr_  = 1'b1;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      exp_q.push_back(exp);
      bus.ram_addr = addr;
      bus.ram_rd_  = 1'b0;
      #1;
      sb_check(tag, bus.ram_d_out);
      bus.ram_rd_  = 1'b1;
   endtask

   // Sends one byte and checks every bit mid-period plus the BUSY window length.
   task automatic uart_frame(input string tag, input logic [7:0] b, input bit dup);
      int busy_cnt = 0;
      exp_q.push_back(8'h00);
      for (int i = 0; i < 8; i++) exp_q.push_back({7'b0, b[i]});
      exp_q.push_back(8'h01);
      wr(8'hF5, b);
      for (int c = 0; c < 48; c++) begin
         bus.ram_wr_  = 1'b1;
         bus.ram_addr = 8'hF6;
         bus.ram_rd_  = 1'b0;
         #1;
         busy_cnt += int'(bus.ram_d_out[0]);
         bus.ram_rd_  = 1'b1;
         if ((c % 4 == 2) && (c < 40)) sb_check({tag, " bit"}, {7'b0, uart_tx});
         if (dup && c == 4) begin
            bus.ram_addr = 8'hF5;
            bus.ram_d_in = 8'hFF;
            bus.ram_wr_  = 1'b0;
         end
         cyc(1);
      end
      bus.ram_wr_ = 1'b1;
      chk({tag, " busy cycles"}, 8'(busy_cnt), 8'd40);
      chk({tag, " idle line"}, {7'b0, uart_tx}, 8'h01);
   endtask

   initial begin
      rst_         = 1'b0;
      gpio_in      = 8'h00;
      bus.ram_addr = 8'h00;
      bus.ram_d_in = 8'h00;
      bus.ram_rd_  = 1'b1;
      bus.ram_wr_  = 1'b1;
      cyc(3);
      chk("rst gpio_out", gpio_out, 8'h00);
      chk("rst uart_tx", {7'b0, uart_tx}, 8'h01);
      chk("rst irq", {7'b0, timer_irq}, 8'h00);
      rd_chk("rst ctrl", 8'hF3, 8'h00);
      rd_chk("rst cnt", 8'hF2, 8'h00);
      rd_chk("rst stat", 8'hF6, 8'h00);
      rst_ = 1'b1;
      cyc(1);

      // RAM
      wr(8'h10, 8'h5A);
      wr(8'hEF, 8'hA5);
      rd_chk("ram 10", 8'h10, 8'h5A);
      rd_chk("ram EF", 8'hEF, 8'hA5);
      bus.ram_addr = 8'h10;
      #1;
      chk("rd idle zero", bus.ram_d_out, 8'h00);
      exp_q.push_back(8'h5A);
      bus.ram_d_in = 8'h77;
      bus.ram_rd_  = 1'b0;
      bus.ram_wr_  = 1'b0;
      #1;
      sb_check("rd during wr", bus.ram_d_out);
      cyc(1);
      bus.ram_rd_ = 1'b1;
      bus.ram_wr_ = 1'b1;
      rd_chk("ram after rw", 8'h10, 8'h77);

      // GPIO and reserved space
      wr(8'hF0, 8'h3C);
      chk("gpio_out", gpio_out, 8'h3C);
      rd_chk("gpio_out rd", 8'hF0, 8'h3C);
      wr(8'hF8, 8'h55);
      rd_chk("reserved F8", 8'hF8, 8'h00);
      gpio_in = 8'h81;
      rd_chk("gpio_in 0 edges", 8'hF1, 8'h00);
      cyc(1);
      rd_chk("gpio_in 1 edge", 8'hF1, 8'h00);
      cyc(1);
      rd_chk("gpio_in 2 edges", 8'hF1, 8'h81);

      // Timer auto-reload
      wr(8'hF4, 8'hFD);
      wr(8'hF2, 8'hFD);
      wr(8'hF3, 8'h03);
      rd_chk("auto cnt0", 8'hF2, 8'hFD);
      cyc(1);
      rd_chk("auto cnt1", 8'hF2, 8'hFE);
      cyc(1);
      rd_chk("auto cnt2", 8'hF2, 8'hFF);
      chk("auto irq pre", {7'b0, timer_irq}, 8'h00);
      cyc(1);
      rd_chk("auto reload", 8'hF2, 8'hFD);
      chk("auto irq", {7'b0, timer_irq}, 8'h01);
      rd_chk("auto ctrl", 8'hF3, 8'h07);
      wr(8'hF3, 8'h04);
      chk("auto w1c", {7'b0, timer_irq}, 8'h00);

      // Set and W1C in the same cycle: set wins
      wr(8'hF2, 8'hFE);
      wr(8'hF3, 8'h03);
      cyc(1);
      wr(8'hF3, 8'h07);
      chk("set beats clr", {7'b0, timer_irq}, 8'h01);
      wr(8'hF3, 8'h04);
      chk("clr after", {7'b0, timer_irq}, 8'h00);

      // Timer one-shot
      wr(8'hF2, 8'hFE);
      wr(8'hF3, 8'h01);
      cyc(1);
      chk("oneshot pre irq", {7'b0, timer_irq}, 8'h00);
      cyc(1);
      rd_chk("oneshot ctrl", 8'hF3, 8'h04);
      rd_chk("oneshot cnt", 8'hF2, 8'hFF);
      cyc(2);
      rd_chk("oneshot hold", 8'hF2, 8'hFF);
      wr(8'hF3, 8'h04);

      // CNT write on the overflow cycle
      wr(8'hF2, 8'hFE);
      wr(8'hF3, 8'h01);
      cyc(1);
      wr(8'hF2, 8'h10);
      chk("conflict irq", {7'b0, timer_irq}, 8'h00);
      rd_chk("conflict cnt", 8'hF2, 8'h10);
      wr(8'hF3, 8'h00);

      // UART frame with an ignored second write
      uart_frame("uart A5", 8'hA5, 1'b1);

      // Reset mid-frame
      wr(8'hF5, 8'h01);
      cyc(11);
      rst_ = 1'b0;
      cyc(1);
      chk("midrst tx", {7'b0, uart_tx}, 8'h01);
      rd_chk("midrst busy", 8'hF6, 8'h00);
      chk("midrst gpio", gpio_out, 8'h00);
      rst_ = 1'b1;
      cyc(1);
      uart_frame("uart 01", 8'h01, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
